// File: rtl/multicycle_control.sv
// multicycle_control
// Control FSM for the multicycle RV64 datapath. Sequences every supported
// instruction (add/sub/and/or/xor, addi/andi/ori/xori, ld, sd, beq) through
// FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK. Any other encoding traps.
// A trap is absorbing until reset.
//
// Ports
//   clk, reset      : clock and asynchronous active-high reset
//   instruction_in  : instruction register contents from the datapath
//   PCWrite .. IRWrite : datapath control flags (all 0 while reset is high)
//   trap            : sticky illegal-instruction flag
//   retire          : pulse on the last cycle of each completed instruction
//   retired_count   : retired instruction count (wraps)
//   state_out       : current state encoding, for debug
module multicycle_control #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction_in,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCSource,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic        LoadAOut,
  output logic        RegWrite,
  output logic        LoadRegA,
  output logic        LoadRegB,
  output logic        MemToReg,
  output logic        DMemOp,
  output logic        LoadMDR,
  output logic        IMemRead,
  output logic        IRWrite,
  output logic        trap,
  output logic        retire,
  output logic [31:0] retired_count,
  output logic [3:0]  state_out
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_READ  = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_MEM_WB    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] retired_count_q, retired_count_d;
  logic        trap_q, trap_d;

  // Ungated control values; reset masks them at the ports.
  logic       pc_write_c, pc_write_cond_c, pc_source_c, alu_src_a_c;
  logic [1:0] alu_src_b_c;
  logic [2:0] alu_op_c;
  logic       load_aout_c, reg_write_c, load_reg_a_c, load_reg_b_c;
  logic       mem_to_reg_c, dmem_op_c, load_mdr_c, imem_read_c, ir_write_c;
  logic       retire_c;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       bit30;
  logic       cnt_last;

  assign opcode   = instruction_in[6:0];
  assign funct3   = instruction_in[14:12];
  assign bit30    = instruction_in[30];
  assign cnt_last = (cnt_q == CNT_LAST);

  // Register/immediate fields are consumed by the datapath, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = &{instruction_in[31], instruction_in[29:15],
                               instruction_in[11:7]};

  function automatic logic [2:0] alu_fn(input logic [2:0] f3, input logic sub_sel);
    case (f3)
      3'b000:  alu_fn = sub_sel ? OP_SUB : OP_ADD;
      3'b111:  alu_fn = OP_AND;
      3'b110:  alu_fn = OP_OR;
      3'b100:  alu_fn = OP_XOR;
      default: alu_fn = OP_ADD;
    endcase
  endfunction

  always_comb begin
    state_d         = state_q;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    pc_source_c     = 1'b0;
    alu_src_a_c     = 1'b0;
    alu_src_b_c     = 2'd0;
    alu_op_c        = OP_ADD;
    load_aout_c     = 1'b0;
    reg_write_c     = 1'b0;
    load_reg_a_c    = 1'b0;
    load_reg_b_c    = 1'b0;
    mem_to_reg_c    = 1'b0;
    dmem_op_c       = 1'b0;
    load_mdr_c      = 1'b0;
    imem_read_c     = 1'b0;
    ir_write_c      = 1'b0;
    retire_c        = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_read_c = 1'b1;
        if (cnt_last) begin
          // Instruction arrives: latch IR and advance PC by 4.
          ir_write_c  = 1'b1;
          pc_write_c  = 1'b1;
          alu_src_b_c = 2'd1;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target = (PC+4) + imm*2 computed speculatively.
        load_reg_a_c = 1'b1;
        load_reg_b_c = 1'b1;
        alu_src_b_c  = 2'd3;
        load_aout_c  = 1'b1;
        state_d      = S_TRAP;
        case (opcode)
          7'b0110011: begin
            if ((funct3 == 3'b000) ||
                (!bit30 && (funct3 == 3'b111 || funct3 == 3'b110 || funct3 == 3'b100)))
              state_d = S_EXEC_R;
          end
          7'b0010011: begin
            if (funct3 == 3'b000 || funct3 == 3'b111 || funct3 == 3'b110 || funct3 == 3'b100)
              state_d = S_EXEC_I;
          end
          7'b0000011, 7'b0100011: begin
            if (funct3 == 3'b011) state_d = S_MEM_ADDR;
          end
          7'b1100011: begin
            if (funct3 == 3'b000) state_d = S_BRANCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = alu_fn(funct3, bit30);
        load_aout_c = 1'b1;
        state_d     = S_ALU_WB;
      end
      S_EXEC_I: begin
        // bit 30 belongs to the immediate here, so it never selects SUB.
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'd2;
        alu_op_c    = alu_fn(funct3, 1'b0);
        load_aout_c = 1'b1;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'd2;
        load_aout_c = 1'b1;
        state_d     = (opcode == 7'b0000011) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        if (cnt_last) begin
          load_mdr_c = 1'b1;
          state_d    = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        retire_c     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WRITE: begin
        dmem_op_c = 1'b1;
        retire_c  = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c     = 1'b1;
        alu_op_c        = OP_SUB;
        pc_write_cond_c = 1'b1;
        pc_source_c     = 1'b1;
        retire_c        = 1'b1;
        state_d         = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  always_comb begin
    // Counter only runs while waiting on memory; any state change clears it.
    cnt_d = 4'd0;
    if ((state_d == state_q) && (state_q == S_FETCH || state_q == S_MEM_READ))
      cnt_d = cnt_q + 4'd1;
    retired_count_d = retired_count_q + (retire_c ? 32'd1 : 32'd0);
    trap_d          = trap_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_FETCH;
      cnt_q           <= 4'd0;
      retired_count_q <= 32'd0;
      trap_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      retired_count_q <= retired_count_d;
      trap_q          <= trap_d;
    end
  end

  // Every output is held low for the whole time reset is asserted.
  assign PCWrite       = pc_write_c      & ~reset;
  assign PCWriteCond   = pc_write_cond_c & ~reset;
  assign PCSource      = pc_source_c     & ~reset;
  assign ALUSrcA       = alu_src_a_c     & ~reset;
  assign ALUSrcB       = alu_src_b_c     & {2{~reset}};
  assign ALUOp         = alu_op_c        & {3{~reset}};
  assign LoadAOut      = load_aout_c     & ~reset;
  assign RegWrite      = reg_write_c     & ~reset;
  assign LoadRegA      = load_reg_a_c    & ~reset;
  assign LoadRegB      = load_reg_b_c    & ~reset;
  assign MemToReg      = mem_to_reg_c    & ~reset;
  assign DMemOp        = dmem_op_c       & ~reset;
  assign LoadMDR       = load_mdr_c      & ~reset;
  assign IMemRead      = imem_read_c     & ~reset;
  assign IRWrite       = ir_write_c      & ~reset;
  assign retire        = retire_c        & ~reset;
  assign trap          = trap_q          & ~reset;
  assign retired_count = retired_count_q & {32{~reset}};
  assign state_out     = state_q         & {4{~reset}};

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM that drives every control flag of the multicycle RV64 datapath (`processing`). It consumes the datapath's `instruction_out`.
- Sequences FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK for the supported subset: R-type add/sub/and/or/xor, I-type addi/andi/ori/xori, ld, sd, beq.
- Traps on anything else.
- Also keeps a retired-instruction counter and exports state for debug.

Parameters:
- MEM_LATENCY, 1, cycles from memory address valid to read data valid (instr and data memory). Legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- instruction_in  in  32  instruction register contents (datapath instruction_out)
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero
- PCSource  out  1  0=ALU result, 1=ALUOut register
- ALUSrcA  out  1  0=PC, 1=reg A
- ALUSrcB  out  2  0=reg B, 1=const 4, 2=imm, 3=imm*2
- ALUOp  out  3  ALU function: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR
- LoadAOut  out  1  load ALUOut register
- RegWrite  out  1  regfile write
- LoadRegA  out  1  load reg A
- LoadRegB  out  1  load reg B
- MemToReg  out  1  0=ALUOut, 1=MDR
- DMemOp  out  1  1=data memory write
- LoadMDR  out  1  load memory data register
- IMemRead  out  1  instruction fetch active
- IRWrite  out  1  load instruction register
- trap  out  1  sticky illegal-instruction flag
- retire  out  1  one-cycle pulse on last cycle of each completed instruction
- retired_count  out  32  retired instructions, wraps 0xFFFFFFFF->0
- state_out  out  4  current state encoding (debug)

Behaviour:
Reset:
- While reset=1, every output is 0.
- State is forced to FETCH, the latency counter to 0, retired_count to 0 and trap to 0.
- Reset mid-instruction abandons the instruction with no partial write.

Default outputs:
- All flags default to 0 / 000 unless the state lists them.

State encodings (state_out):
- FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_READ=5, MEM_WRITE=6, MEM_WB=7, ALU_WB=8, BRANCH=9, TRAP=15.

Latency counter:
- cnt counts 0..MEM_LATENCY-1 in FETCH and MEM_READ.
- Cleared on every state change.

State actions and transitions:
- FETCH: IMemRead=1 every cycle. On cnt==MEM_LATENCY-1 only, also drive IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSource=0 (PC<=PC+4), then go to DECODE.
- DECODE: LoadRegA=1, LoadRegB=1, ALUSrcA=0, ALUSrcB=3, ALUOp=ADD, LoadAOut=1. This forms the branch target from the already-incremented PC. Legality is checked on instruction_in[6:0], [14:12] and [30]:
  - 0110011 (f3 000 with [30]=0/1, 111, 110, 100; [30] must be 0 except sub) -> EXEC_R
  - 0010011 (f3 000, 111, 110, 100) -> EXEC_I
  - 0000011 with f3=011 -> MEM_ADDR
  - 0100011 with f3=011 -> MEM_ADDR
  - 1100011 with f3=000 -> BRANCH
  - anything else -> TRAP
- EXEC_R: ALUSrcA=1, ALUSrcB=0, LoadAOut=1. ALUOp from funct3/[30]: 000/0 ADD, 000/1 SUB, 111 AND, 110 OR, 100 XOR. Next state ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=2, LoadAOut=1. ALUOp per funct3 as for EXEC_R, with [30] ignored. Next state ALU_WB.
- ALU_WB: RegWrite=1, MemToReg=0, retire=1. Next state FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=ADD, LoadAOut=1. Next state MEM_READ for a load, MEM_WRITE for a store.
- MEM_READ: DMemOp=0. LoadMDR=1 on cnt==MEM_LATENCY-1, then go to MEM_WB.
- MEM_WB: RegWrite=1, MemToReg=1, retire=1. Next state FETCH.
- MEM_WRITE: DMemOp=1 for exactly one cycle, retire=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=SUB, PCWriteCond=1, PCSource=1, PCWrite=0, retire=1. Next state FETCH.
- TRAP: trap=1 and all flags 0. TRAP is absorbing; only reset exits it. Not retired.

Cycles per instruction (L=MEM_LATENCY):
- R/I-type: L+3
- store: L+3
- branch: L+2
- load: 2L+3

Other rules:
- retired_count increments on the same edge that ends each retire cycle.
- rd=x0 needs no special handling; the regfile ignores that write.

Test Plan:
1. Reset, L=1, instruction_in=0x002081B3 (add x3,x1,x2) -> states 0,1,2,8,0. IRWrite and PCWrite in cycle 0; EXEC_R ALUOp=000; RegWrite=1, MemToReg=0 in cycle 3; retired_count=1.
2. L=1, instruction_in=0x40208233 (sub x4,x1,x2) -> EXEC_R ALUOp=001. Same with 0x0020F1B3 (and) -> ALUOp=010.
3. L=3, instruction_in=0x0080B283 (ld x5,8(x1)):
   - IMemRead high 3 cycles, IRWrite only in the 3rd.
   - MEM_ADDR ALUSrcB=2; MEM_READ lasts 3 cycles, LoadMDR only in the last.
   - MEM_WB has MemToReg=1; total 9 cycles.
4. L=1, instruction_in=0x0050B823 (sd x5,16(x1)) -> DMemOp high exactly one cycle (state 6), RegWrite never high. Then 0x00000063 (beq) -> BRANCH with PCWriteCond=1, PCSource=1, ALUOp=001, PCWrite=0.
5. instruction_in=0xFFFFFFFF -> DECODE goes to TRAP. trap=1, all flags 0 for 20+ cycles, retired_count unchanged. Asserting reset clears trap, and the FSM restarts in FETCH.
6. Assert reset in MEM_READ, then preload retired_count to 0xFFFFFFFF via 2^32 retires (or force) -> reset: no LoadMDR/RegWrite, state=0, outputs 0 while reset high. Wrap case: next retire gives retired_count=0.
